// File: rtl/ddr_cmd_arbiter.sv
// Two-port arbiter in front of the MIG user-port command interface.
// Port 0 (display reads) has fixed priority; a starvation counter forces port 1 through.
module ddr_cmd_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic        cmd_full,
  input  logic [6:0]  wr_count,
  input  logic        p0_req,
  input  logic [2:0]  p0_instr,
  input  logic [5:0]  p0_bl,
  input  logic [29:0] p0_addr,
  output logic        p0_ack,
  input  logic        p1_req,
  input  logic [2:0]  p1_instr,
  input  logic [5:0]  p1_bl,
  input  logic [29:0] p1_addr,
  output logic        p1_ack,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  output logic        grant_id,
  output logic        busy
);

  typedef enum logic [1:0] {
    WAIT_CALIB = 2'd0,
    IDLE       = 2'd1,
    ISSUE      = 2'd2,
    GAP        = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t            state_reg, state_next;
  logic              cal_meta_reg, cal_s_reg;
  logic [CNT_W-1:0]  starve_reg, starve_next;
  logic              cmd_en_reg, cmd_en_next;
  logic [1:0]        ack_reg, ack_next;
  logic              busy_reg, busy_next;
  logic              grant_id_reg, grant_id_next;
  logic [2:0]        cmd_instr_reg, cmd_instr_next;
  logic [5:0]        cmd_bl_reg, cmd_bl_next;
  logic [29:0]       cmd_addr_reg, cmd_addr_next;

  // Per-port views so eligibility is described once for both requesters.
  logic [1:0]        req_v;
  logic [2:0]        instr_v [2];
  logic [5:0]        bl_v    [2];
  logic [29:0]       addr_v  [2];
  logic [1:0]        elig;

  assign req_v[0]   = p0_req;
  assign req_v[1]   = p1_req;
  assign instr_v[0] = p0_instr;
  assign instr_v[1] = p1_instr;
  assign bl_v[0]    = p0_bl;
  assign bl_v[1]    = p1_bl;
  assign addr_v[0]  = p0_addr;
  assign addr_v[1]  = p1_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic is_write;
      logic data_ok;
      // Writes (000, 010) wait until the whole burst is already in the write-data FIFO.
      assign is_write = ~instr_v[gi][2] & ~instr_v[gi][0];
      assign data_ok  = ~is_write | (wr_count >= ({1'b0, bl_v[gi]} + 7'd1));
      assign elig[gi] = req_v[gi] & ~cmd_full & data_ok;
    end
  endgenerate

  logic force_p1;
  logic win_valid;
  logic win_id;

  assign force_p1  = (starve_reg >= LIMIT) & elig[1];
  assign win_valid = elig[0] | elig[1];
  assign win_id    = force_p1 | ~elig[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cal_meta_reg <= 1'b0;
      cal_s_reg    <= 1'b0;
    end else begin
      cal_meta_reg <= mem_calib_done;
      cal_s_reg    <= cal_meta_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= WAIT_CALIB;
      starve_reg    <= '0;
      cmd_en_reg    <= 1'b0;
      ack_reg       <= 2'b00;
      busy_reg      <= 1'b0;
      grant_id_reg  <= 1'b0;
      cmd_instr_reg <= 3'd0;
      cmd_bl_reg    <= 6'd0;
      cmd_addr_reg  <= 30'd0;
    end else begin
      state_reg     <= state_next;
      starve_reg    <= starve_next;
      cmd_en_reg    <= cmd_en_next;
      ack_reg       <= ack_next;
      busy_reg      <= busy_next;
      grant_id_reg  <= grant_id_next;
      cmd_instr_reg <= cmd_instr_next;
      cmd_bl_reg    <= cmd_bl_next;
      cmd_addr_reg  <= cmd_addr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    starve_next    = starve_reg;
    cmd_en_next    = 1'b0;
    ack_next       = 2'b00;
    busy_next      = 1'b0;
    grant_id_next  = grant_id_reg;
    cmd_instr_next = cmd_instr_reg;
    cmd_bl_next    = cmd_bl_reg;
    cmd_addr_next  = cmd_addr_reg;

    case (state_reg)
      WAIT_CALIB: begin
        if (cal_s_reg) state_next = IDLE;
      end
      IDLE: begin
        if (!p1_req) starve_next = '0;
        if (!cal_s_reg) begin
          state_next = WAIT_CALIB;
        end else if (win_valid) begin
          state_next             = ISSUE;
          cmd_en_next            = 1'b1;
          busy_next              = 1'b1;
          ack_next[win_id]       = 1'b1;
          grant_id_next          = win_id;
          cmd_instr_next         = instr_v[win_id];
          cmd_bl_next            = bl_v[win_id];
          cmd_addr_next          = addr_v[win_id];
          // Only a p0 win that overrode an eligible p1 counts as a lost arbitration.
          if (win_id)
            starve_next = '0;
          else if (elig[1] && (starve_reg < LIMIT))
            starve_next = starve_reg + CNT_W'(1);
        end
      end
      ISSUE: begin
        state_next = GAP;
        busy_next  = 1'b1;
      end
      GAP: begin
        state_next = IDLE;
      end
      default: state_next = WAIT_CALIB;
    endcase
  end

  assign cmd_en        = cmd_en_reg;
  assign p0_ack        = ack_reg[0];
  assign p1_ack        = ack_reg[1];
  assign busy          = busy_reg;
  assign grant_id      = grant_id_reg;
  assign cmd_instr     = cmd_instr_reg;
  assign cmd_bl        = cmd_bl_reg;
  assign cmd_byte_addr = cmd_addr_reg;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Scoreboard bench for ddr_cmd_arbiter: expected commands are queued as stimulus is
// driven and compared whenever cmd_en is seen.
module tb_ddr_cmd_arbiter;

  logic        clk;
  logic        reset;
  logic        mem_calib_done;
  logic        cmd_full;
  logic [6:0]  wr_count;
  logic        p0_req;
  logic [2:0]  p0_instr;
  logic [5:0]  p0_bl;
  logic [29:0] p0_addr;
  logic        p0_ack;
  logic        p1_req;
  logic [2:0]  p1_instr;
  logic [5:0]  p1_bl;
  logic [29:0] p1_addr;
  logic        p1_ack;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        grant_id;
  logic        busy;

  ddr_cmd_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done),
    .cmd_full(cmd_full), .wr_count(wr_count),
    .p0_req(p0_req), .p0_instr(p0_instr), .p0_bl(p0_bl), .p0_addr(p0_addr), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_instr(p1_instr), .p1_bl(p1_bl), .p1_addr(p1_addr), .p1_ack(p1_ack),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_grants = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  logic prev_en = 1'b0;
  logic spacing_en = 1'b0;
  logic spacing_have = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic port, input logic [2:0] instr,
                          input logic [5:0] bl, input logic [29:0] addr);
    exp_t e;
    e.port = port; e.instr = instr; e.bl = bl; e.addr = addr;
    exp_q.push_back(e);
  endtask

  // Monitor: one line per observed command, compared against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset && cmd_en) begin
      check("cmd_en_b2b", {31'd0, prev_en}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("cmd: port=%0d instr=%0d bl=%0d addr=%0h (exp port=%0d instr=%0d bl=%0d addr=%0h)",
                 grant_id, cmd_instr, cmd_bl, cmd_byte_addr, e.port, e.instr, e.bl, e.addr);
        check("grant_id", {31'd0, grant_id}, {31'd0, e.port});
        check("cmd_instr", {29'd0, cmd_instr}, {29'd0, e.instr});
        check("cmd_bl", {26'd0, cmd_bl}, {26'd0, e.bl});
        check("cmd_addr", {2'd0, cmd_byte_addr}, {2'd0, e.addr});
        check("p0_ack", {31'd0, p0_ack}, {31'd0, ~e.port});
        check("p1_ack", {31'd0, p1_ack}, {31'd0, e.port});
        check("busy", {31'd0, busy}, 32'd1);
      end
      if (spacing_en) begin
        if (spacing_have) check("spacing", cyc - last_cyc, 32'd3);
        spacing_have = 1'b1;
      end
      last_cyc = cyc;
      n_grants++;
    end
    prev_en = cmd_en;
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  task automatic wait_grants(input int target);
    int budget = 0;
    while (n_grants < target && budget < 300) begin
      @(negedge clk); #1;
      budget++;
    end
    check("grant_timeout", n_grants, target);
  endtask

  // Edges from the current point until cmd_en is seen just after a posedge.
  task automatic measure_lat(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!cmd_en && lat < 30);
  endtask

  task automatic release_reqs();
    @(posedge clk); #1;
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  int lat;
  int base;

  initial begin
    reset = 1'b1; mem_calib_done = 1'b0; cmd_full = 1'b0; wr_count = 7'd0;
    p0_req = 1'b0; p0_instr = 3'd0; p0_bl = 6'd0; p0_addr = 30'd0;
    p1_req = 1'b0; p1_instr = 3'd0; p1_bl = 6'd0; p1_addr = 30'd0;
    wait_cycles(3);
    check("rst_cmd_en", {31'd0, cmd_en}, 32'd0);
    check("rst_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {31'd0, grant_id}, 32'd0);
    check("rst_cmd_fields", {26'd0, cmd_instr, cmd_bl} | {2'd0, cmd_byte_addr}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // 1: request while uncalibrated, then calibrate
    p0_req = 1'b1; p0_instr = 3'b001; p0_bl = 6'd63; p0_addr = 30'h100;
    wait_cycles(10);
    check("t1_no_grant_uncal", n_grants, 32'd0);
    push_exp(1'b0, 3'b001, 6'd63, 30'h100);
    @(negedge clk); mem_calib_done = 1'b1;
    measure_lat(lat);
    check("t1_calib_latency", lat, 32'd4);
    release_reqs();
    wait_cycles(4);

    // 2: p1 write waits for full burst in write FIFO
    base = n_grants;
    wr_count = 7'd10;
    p1_req = 1'b1; p1_instr = 3'b000; p1_bl = 6'd15; p1_addr = 30'h2000;
    wait_cycles(10);
    check("t2_no_grant_wc10", n_grants, base);
    for (int w = 11; w <= 15; w++) begin
      @(negedge clk); wr_count = 7'(w);
    end
    wait_cycles(3);
    check("t2_no_grant_wc15", n_grants, base);
    push_exp(1'b1, 3'b000, 6'd15, 30'h2000);
    @(negedge clk); wr_count = 7'd16;
    wait_grants(base + 1);
    release_reqs();
    wait_cycles(4);

    // 3: both reading continuously -> 8 p0, 1 p1, 3-cycle spacing
    base = n_grants;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 8; k++) push_exp(1'b0, 3'b001, 6'd7, 30'h300);
      push_exp(1'b1, 3'b001, 6'd3, 30'h400);
    end
    spacing_en = 1'b1;
    @(negedge clk);
    p0_req = 1'b1; p0_instr = 3'b001; p0_bl = 6'd7; p0_addr = 30'h300;
    p1_req = 1'b1; p1_instr = 3'b001; p1_bl = 6'd3; p1_addr = 30'h400;
    wait_grants(base + 18);
    release_reqs();
    spacing_en = 1'b0; spacing_have = 1'b0;
    wait_cycles(4);

    // 4: cmd_full blocks both; p0 wins on release
    base = n_grants;
    cmd_full = 1'b1;
    p0_req = 1'b1; p0_addr = 30'h500;
    p1_req = 1'b1; p1_addr = 30'h600;
    wait_cycles(20);
    check("t4_no_grant_full", n_grants, base);
    push_exp(1'b0, 3'b001, 6'd7, 30'h500);
    @(negedge clk); cmd_full = 1'b0;
    wait_grants(base + 1);
    release_reqs();
    wait_cycles(4);

    // 5: reset during ISSUE, then resynchronise calibration
    p0_req = 1'b1; p0_addr = 30'h700;
    measure_lat(lat);
    check("t5_issue_seen", {31'd0, cmd_en}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_cmd_en", {31'd0, cmd_en}, 32'd0);
    check("t5_rst_p0_ack", {31'd0, p0_ack}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    wait_cycles(2);
    base = n_grants;
    push_exp(1'b0, 3'b001, 6'd7, 30'h700);
    @(negedge clk); reset = 1'b0;
    measure_lat(lat);
    check("t5_resync_latency", lat, 32'd4);
    release_reqs();
    wait_cycles(4);

    // 6: calibration lost while a request is pending in IDLE
    base = n_grants;
    cmd_full = 1'b1;
    p0_req = 1'b1; p0_addr = 30'h800;
    wait_cycles(3);
    mem_calib_done = 1'b0;
    wait_cycles(5);
    cmd_full = 1'b0;
    wait_cycles(10);
    check("t6_no_grant_uncal", n_grants, base);
    push_exp(1'b0, 3'b001, 6'd7, 30'h800);
    @(negedge clk); mem_calib_done = 1'b1;
    measure_lat(lat);
    check("t6_recal_latency", lat, 32'd4);
    release_reqs();
    wait_cycles(4);

    // 7: write 010 boundary on p0, then 1xx on p1 with no data check
    base = n_grants;
    wr_count = 7'd0;
    p0_req = 1'b1; p0_instr = 3'b010; p0_bl = 6'd0; p0_addr = 30'h40;
    wait_cycles(6);
    check("t7_no_grant_wc0", n_grants, base);
    push_exp(1'b0, 3'b010, 6'd0, 30'h40);
    @(negedge clk); wr_count = 7'd1;
    wait_grants(base + 1);
    release_reqs();
    wait_cycles(4);
    wr_count = 7'd0;
    push_exp(1'b1, 3'b100, 6'd63, 30'h80);
    p1_req = 1'b1; p1_instr = 3'b100; p1_bl = 6'd63; p1_addr = 30'h80;
    wait_grants(base + 2);
    release_reqs();
    wait_cycles(6);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
